// File: rtl/aho_tx.sv
// aho_tx: turns each sampled AHO event into an "AHO\n" byte message on a valid/ready stream.
// Optional build macro AHO_TX_CNT_EN adds a 16-bit CNT output counting accepted events.
module aho_tx #(
    parameter int PEND_MAX = 4,
    parameter int PEND_W   = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       AHO,
    output logic [7:0] TXD,
    output logic       TXV,
    input  logic       TXR,
    output logic       BUSY,
    output logic       OVF
`ifdef AHO_TX_CNT_EN
    ,
    output logic [15:0] CNT
`endif
);

    // state | meaning
    // IDLE  | no message in progress, TXV low, TXD holds last byte
    // SEND  | presenting byte idx_q of "AHO\n"
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [7:0]          txd_q, txd_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                ovf_q, ovf_d;
    logic                start;
    logic                accept;

    function automatic logic [7:0] msg_byte(input logic [1:0] i);
        case (i)
            2'd0:    msg_byte = 8'h41;
            2'd1:    msg_byte = 8'h48;
            2'd2:    msg_byte = 8'h4F;
            default: msg_byte = 8'h0A;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        txd_d   = txd_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    state_d = SEND;
                    idx_d   = 2'd0;
                    txd_d   = msg_byte(2'd0);
                    start   = 1'b1;
                end
            end
            SEND: begin
                if (TXR) begin
                    if (idx_q == 2'd3) begin
                        // Chain straight into the next message to avoid an idle bubble.
                        if (pend_q != '0) begin
                            idx_d = 2'd0;
                            txd_d = msg_byte(2'd0);
                            start = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                        txd_d = msg_byte(idx_q + 2'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept = AHO && ((pend_q != PEND_W'(PEND_MAX)) || start);
        ovf_d  = ovf_q | (AHO & ~accept);
        pend_d = pend_q;
        case ({accept, start})
            2'b10:   pend_d = pend_q + PEND_W'(1);
            2'b01:   pend_d = pend_q - PEND_W'(1);
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            txd_q   <= 8'h00;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            txd_q   <= txd_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef AHO_TX_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) cnt_q <= 16'd0;
        else      cnt_q <= cnt_d;
    end

    assign CNT = cnt_q;
`endif

    assign TXD  = txd_q;
    assign TXV  = (state_q == SEND);
    assign BUSY = (state_q == SEND);
    assign OVF  = ovf_q;

endmodule
